// File: rtl/mux_8way_arbiter_if.sv
// Bus bundle for the 8-way fan-in collector.
//   in_valid/in_data/in_ready : eight source channels, word i at [i*WIDTH +: WIDTH]
//   out_valid/out_data/out_sel/out_ready : single registered output channel
// slave  : collector side (drives in_ready and the output channel)
// master : environment side (drives sources and out_ready)
interface mux_8way_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_8way_arbiter.sv
// Eight-to-one round-robin fan-in collector with a one-entry output register.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_8way_arbiter_if.slave
//           in_valid[7:0], in_data[8*WIDTH-1:0] in, in_ready[7:0] out (one-hot or zero,
//           combinational on out_ready), out_valid/out_data/out_sel registered out,
//           out_ready in.
module mux_8way_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_8way_arbiter_if.slave     bus
);

  localparam int unsigned N_SRC = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_sel_q, out_sel_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0]   grant_c;
  logic [SEL_W-1:0]   scan_idx;
  logic               found;
  logic               load_en_c;
  logic [N_SRC-1:0]   in_ready_c;

  // First valid source at or after rr_ptr, wrapping modulo 8.
  always_comb begin
    grant_c  = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      scan_idx = rr_ptr_q + 3'(k);
      if (!found && bus.in_valid[scan_idx]) begin
        grant_c = scan_idx;
        found   = 1'b1;
      end
    end
  end

  // Load when the register is empty or being drained this cycle.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    rr_ptr_d   = rr_ptr_q;
    in_ready_c = '0;
    load_en_c  = ((state_q == ST_EMPTY) || bus.out_ready) && (|bus.in_valid);

    if (load_en_c) begin
      in_ready_c[grant_c] = 1'b1;
      state_d             = ST_FULL;
      out_data_d          = bus.in_data[32'(grant_c) * WIDTH +: WIDTH];
      out_sel_d           = grant_c;
      rr_ptr_d            = grant_c + 3'd1;
    end else if ((state_q == ST_FULL) && bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State and output register; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_sel_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // in_ready is forced low during reset since load_en can be high combinationally.
  assign bus.in_ready  = rst_n ? in_ready_c : '0;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_8way_arbiter.sv
// Directed self-checking bench for mux_8way_arbiter.
module tb_mux_8way_arbiter;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mux_8way_arbiter_if #(.WIDTH(WIDTH)) bus_if ();

  mux_8way_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic load_ramp_data();
    for (int i = 0; i < 8; i++) bus_if.in_data[i*WIDTH +: WIDTH] = 16'h1000 + 16'(i);
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus_if.in_valid  = 8'h00;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus_if.in_valid  = 8'h00;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", c, bus_if.out_valid); end
      total++;
      if (bus_if.out_data !== 16'h0000) begin bad++; $display("FAIL reset_data cyc=%0d got=%h exp=0000", c, bus_if.out_data); end
      total++;
      if (bus_if.out_sel !== 3'd0) begin bad++; $display("FAIL reset_sel cyc=%0d got=%0d exp=0", c, bus_if.out_sel); end
      total++;
      if (bus_if.in_ready !== 8'h00) begin bad++; $display("FAIL reset_ready cyc=%0d got=%h exp=00", c, bus_if.in_ready); end
    end
  endtask

  task automatic test_single();
    bus_if.in_data[5*WIDTH +: WIDTH] = 16'hBEEF;
    bus_if.in_valid  = 8'b0010_0000;
    bus_if.out_ready = 1'b1;
    #1;
    total++;
    if (bus_if.in_ready !== 8'b0010_0000) begin bad++; $display("FAIL single_ready got=%h exp=20", bus_if.in_ready); end
    @(posedge clk); #1;
    bus_if.in_valid = 8'h00;
    total++;
    if (bus_if.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus_if.out_valid); end
    total++;
    if (bus_if.out_data !== 16'hBEEF) begin bad++; $display("FAIL single_data got=%h exp=beef", bus_if.out_data); end
    total++;
    if (bus_if.out_sel !== 3'd5) begin bad++; $display("FAIL single_sel got=%0d exp=5", bus_if.out_sel); end
    // Drain with no new source: register empties, data/sel hold.
    @(posedge clk); #1;
    total++;
    if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", bus_if.out_valid); end
    total++;
    if (bus_if.out_data !== 16'hBEEF || bus_if.out_sel !== 3'd5) begin
      bad++; $display("FAIL drain_hold got=%h/%0d exp=beef/5", bus_if.out_data, bus_if.out_sel);
    end
    // Idle cycles must not move the pointer: next grant from all-valid is 6.
    repeat (3) @(posedge clk);
    #1;
    load_ramp_data();
    bus_if.in_valid = 8'hFF;
    #1;
    total++;
    if (bus_if.in_ready !== 8'b0100_0000) begin bad++; $display("FAIL single_ptr6 got=%h exp=40", bus_if.in_ready); end
    bus_if.in_valid = 8'h00;
  endtask

  task automatic test_round_robin();
    do_reset();
    load_ramp_data();
    bus_if.in_valid  = 8'hFF;
    bus_if.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      total++;
      if (bus_if.in_ready !== (8'h01 << (k % 8))) begin
        bad++; $display("FAIL rr_ready k=%0d got=%h exp=%h", k, bus_if.in_ready, 8'h01 << (k % 8));
      end
      @(posedge clk); #1;
      total++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_sel !== 3'(k % 8) || bus_if.out_data !== 16'h1000 + 16'(k % 8)) begin
        bad++; $display("FAIL rr_out k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, bus_if.out_valid, bus_if.out_sel,
                        bus_if.out_data, k % 8, 16'h1000 + 16'(k % 8));
      end
    end
    bus_if.in_valid = 8'h00;
  endtask

  task automatic test_backpressure();
    do_reset();
    load_ramp_data();
    bus_if.in_valid  = 8'hFF;
    bus_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus_if.out_ready = 1'b0;
    total++;
    if (bus_if.out_sel !== 3'd2 || bus_if.out_data !== 16'h1002) begin
      bad++; $display("FAIL bp_setup got=%0d/%h exp=2/1002", bus_if.out_sel, bus_if.out_data);
    end
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (bus_if.in_ready !== 8'h00) begin bad++; $display("FAIL bp_ready cyc=%0d got=%h exp=00", c, bus_if.in_ready); end
      @(posedge clk); #1;
      total++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_sel !== 3'd2 || bus_if.out_data !== 16'h1002) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%h exp=1/2/1002", c, bus_if.out_valid, bus_if.out_sel, bus_if.out_data);
      end
    end
    bus_if.out_ready = 1'b1;
    #1;
    total++;
    if (bus_if.in_ready !== 8'h08) begin bad++; $display("FAIL bp_release_ready got=%h exp=08", bus_if.in_ready); end
    @(posedge clk); #1;
    total++;
    if (bus_if.out_sel !== 3'd3 || bus_if.out_data !== 16'h1003) begin
      bad++; $display("FAIL bp_release_out got=%0d/%h exp=3/1003", bus_if.out_sel, bus_if.out_data);
    end
    bus_if.in_valid = 8'h00;
  endtask

  task automatic test_pointer_skip();
    do_reset();
    load_ramp_data();
    bus_if.in_valid  = 8'b0010_0000;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 8'b0000_0101;
    #1;
    total++;
    if (bus_if.in_ready !== 8'h01) begin bad++; $display("FAIL skip_ready0 got=%h exp=01", bus_if.in_ready); end
    @(posedge clk); #1;
    total++;
    if (bus_if.out_sel !== 3'd0 || bus_if.out_data !== 16'h1000) begin
      bad++; $display("FAIL skip_out0 got=%0d/%h exp=0/1000", bus_if.out_sel, bus_if.out_data);
    end
    total++;
    if (bus_if.in_ready !== 8'h04) begin bad++; $display("FAIL skip_ready2 got=%h exp=04", bus_if.in_ready); end
    @(posedge clk); #1;
    total++;
    if (bus_if.out_sel !== 3'd2 || bus_if.out_data !== 16'h1002) begin
      bad++; $display("FAIL skip_out2 got=%0d/%h exp=2/1002", bus_if.out_sel, bus_if.out_data);
    end
    bus_if.in_valid = 8'hFF;
    #1;
    total++;
    if (bus_if.in_ready !== 8'h08) begin bad++; $display("FAIL skip_ptr3 got=%h exp=08", bus_if.in_ready); end
    bus_if.in_valid = 8'h00;
  endtask

  task automatic test_async_reset();
    do_reset();
    load_ramp_data();
    bus_if.in_valid  = 8'hFF;
    bus_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_sel !== 3'd2) begin
      bad++; $display("FAIL ar_pre got=%b/%0d exp=1/2", bus_if.out_valid, bus_if.out_sel);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (bus_if.out_valid !== 1'b0 || bus_if.out_data !== 16'h0000 || bus_if.out_sel !== 3'd0) begin
      bad++; $display("FAIL ar_async got=%b/%h/%0d exp=0/0000/0", bus_if.out_valid, bus_if.out_data, bus_if.out_sel);
    end
    total++;
    if (bus_if.in_ready !== 8'h00) begin bad++; $display("FAIL ar_ready got=%h exp=00", bus_if.in_ready); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_sel !== 3'd0 || bus_if.out_data !== 16'h1000) begin
      bad++; $display("FAIL ar_first got=%b/%0d/%h exp=1/0/1000", bus_if.out_valid, bus_if.out_sel, bus_if.out_data);
    end
    bus_if.in_valid = 8'h00;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
